// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sizes, sprite codes and blitter states
package sprite_pkg;
  localparam int SPRITE_DIM     = 32;
  localparam int ROM_ADDR_WIDTH = 7;
  localparam int FB_ADDR_WIDTH  = 19;
  localparam int FB_W_DEFAULT   = 640;
  localparam int FB_H_DEFAULT   = 480;

  typedef enum logic [1:0] {
    SPR_WALL   = 2'd0,
    SPR_FLOOR  = 2'd1,
    SPR_PLAYER = 2'd2,
    SPR_UNUSED = 2'd3
  } sprite_code_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } blit_state_e;
endpackage

// File: rtl/sprite_blitter_if.sv
// rtl/sprite_blitter_if.sv - sprite ROM read port and frame-buffer write handshake
interface sprite_blitter_if;
  logic [sprite_pkg::ROM_ADDR_WIDTH-1:0] rom_addr;
  logic [sprite_pkg::SPRITE_DIM-1:0]     rom_data;
  logic                                  fb_valid;
  logic                                  fb_ready;
  logic [sprite_pkg::FB_ADDR_WIDTH-1:0]  fb_addr;
  logic                                  fb_data;

  modport master (
    output rom_addr, fb_valid, fb_addr, fb_data,
    input  rom_data, fb_ready
  );

  modport slave (
    input  rom_addr, fb_valid, fb_addr, fb_data,
    output rom_data, fb_ready
  );
endinterface

// File: rtl/sprite_row_shifter.sv
// rtl/sprite_row_shifter.sv - row word register shifted left one pixel per column
module sprite_row_shifter
  import sprite_pkg::*;
#(
  parameter int WIDTH = SPRITE_DIM
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);
  logic [WIDTH-1:0] row_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
    end else if (load) begin
      row_q <= din;
    end else if (shift) begin
      row_q <= {row_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = row_q[WIDTH-1];
endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - walks a 32x32 1-bit sprite and emits clipped per-pixel writes
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int FB_W = FB_W_DEFAULT,
  parameter int FB_H = FB_H_DEFAULT
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    start,
  input  logic [1:0]              sprite_code,
  input  logic [9:0]              tile_x,
  input  logic [8:0]              tile_y,
  input  logic                    opaque,
  output logic                    busy,
  output logic                    done,
  sprite_blitter_if.master        bus
);
  localparam logic [4:0] LAST_IDX = 5'(SPRITE_DIM - 1);

  blit_state_e               state_q, state_nxt;
  sprite_code_e              code_q;
  logic [9:0]                x0_q;
  logic                      opq_q;
  logic [4:0]                row_q, col_q;
  logic [10:0]               x_q;
  logic [9:0]                y_q;
  logic [FB_ADDR_WIDTH-1:0]  row_base_q, fb_addr_q;
  logic                      pix_bit, pix_emit, col_step, shift_load;

  sprite_row_shifter #(.WIDTH(SPRITE_DIM)) u_shifter (
    .clk   (Clk),
    .rst_n (Reset_n),
    .load  (shift_load),
    .shift (col_step),
    .din   (bus.rom_data),
    .msb   (pix_bit)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_IDLE;
    else          state_q <= state_nxt;
  end

  // Emission is decoded from registered state only; fb_ready just gates the step.
  always_comb begin
    state_nxt  = state_q;
    busy       = 1'b0;
    done       = 1'b0;
    shift_load = 1'b0;
    col_step   = 1'b0;
    pix_emit   = (state_q == S_EMIT) && (opq_q || pix_bit) &&
                 (x_q < 11'(FB_W)) && (y_q < 10'(FB_H));
    case (state_q)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        busy       = 1'b1;
        shift_load = 1'b1;
        state_nxt  = S_EMIT;
      end
      S_EMIT: begin
        busy     = 1'b1;
        col_step = !pix_emit || bus.fb_ready;
        if (col_step && col_q == LAST_IDX)
          state_nxt = (row_q == LAST_IDX) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Row base accumulates FB_W per row so the only multiply happens once at start.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      code_q     <= SPR_WALL;
      x0_q       <= '0;
      opq_q      <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      fb_addr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          code_q     <= sprite_code_e'(sprite_code);
          x0_q       <= tile_x;
          y_q        <= {1'b0, tile_y};
          opq_q      <= opaque;
          row_q      <= '0;
          row_base_q <= FB_ADDR_WIDTH'(tile_y) * FB_ADDR_WIDTH'(FB_W);
        end
        S_LOAD: begin
          col_q     <= '0;
          x_q       <= {1'b0, x0_q};
          fb_addr_q <= row_base_q + FB_ADDR_WIDTH'(x0_q);
        end
        S_EMIT: if (col_step) begin
          col_q     <= col_q + 5'd1;
          x_q       <= x_q + 11'd1;
          fb_addr_q <= fb_addr_q + 1'b1;
          if (col_q == LAST_IDX && row_q != LAST_IDX) begin
            row_q      <= row_q + 5'd1;
            y_q        <= y_q + 10'd1;
            row_base_q <= row_base_q + FB_ADDR_WIDTH'(FB_W);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_addr = {code_q, row_q};
  assign bus.fb_valid = pix_emit;
  assign bus.fb_addr  = fb_addr_q;
  assign bus.fb_data  = pix_bit;
endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - directed bench for sprite_blitter
module tb_sprite_blitter;
  import sprite_pkg::*;

  logic       Clk;
  logic       Reset_n;
  logic       start;
  logic [1:0] sprite_code;
  logic [9:0] tile_x;
  logic [8:0] tile_y;
  logic       opaque;
  logic       busy;
  logic       done;

  sprite_blitter_if bus();

  sprite_blitter dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .start       (start),
    .sprite_code (sprite_code),
    .tile_x      (tile_x),
    .tile_y      (tile_y),
    .opaque      (opaque),
    .busy        (busy),
    .done        (done),
    .bus         (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Sprite ROM contents: wall alternates solid / edge rows, player has a fixed row 0.
  function automatic logic [31:0] rom_word(input logic [6:0] a);
    case (a[6:5])
      2'd0:    return a[0] ? 32'h8000_0001 : 32'hFFFF_FFFF;
      2'd1:    return 32'h5555_5555;
      2'd2:    return (a[4:0] == 5'd0) ? 32'hC000_0003 : 32'h1800_0018;
      default: return 32'h0;
    endcase
  endfunction

  always_comb bus.rom_data = rom_word(bus.rom_addr);

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt, wr_zero;
  int wr_data[int];
  logic [6:0] rom_q[$];
  logic st_valid, st_stable, st_data;
  logic [18:0] st_addr;

  always @(negedge Clk) begin
    if (Reset_n && bus.fb_valid && bus.fb_ready) begin
      wr_cnt++;
      wr_data[int'(bus.fb_addr)] = int'(bus.fb_data);
      if (!bus.fb_data) wr_zero++;
    end
    if (Reset_n && busy && (rom_q.size() == 0 || rom_q[$] != bus.rom_addr))
      rom_q.push_back(bus.rom_addr);
  end

  function automatic int got(input int a);
    return wr_data.exists(a) ? wr_data[a] : -1;
  endfunction

  task automatic run_sprite(input logic [1:0] code, input logic [9:0] x, input logic [8:0] y,
                            input logic opq, input int stall, input int poke,
                            output int done_cyc);
    int n;
    wr_cnt = 0; wr_zero = 0; wr_data.delete(); rom_q.delete();
    st_valid = 1'b1; st_stable = 1'b1; st_addr = '0; st_data = 1'b0;
    @(posedge Clk); #1;
    start = 1'b1; sprite_code = code; tile_x = x; tile_y = y; opaque = opq; fb_ready_drv(1'b1);
    @(posedge Clk); #1;
    start = 1'b0; n = 1; done_cyc = -1;
    while (n < 3000) begin
      fb_ready_drv(!(n >= 2 && n < 2 + stall));
      if (n >= 2 && n < 2 + stall) begin
        if (n == 2) begin st_addr = bus.fb_addr; st_data = bus.fb_data; end
        if (bus.fb_valid !== 1'b1) st_valid = 1'b0;
        if (bus.fb_addr !== st_addr || bus.fb_data !== st_data) st_stable = 1'b0;
      end
      start = (n == poke);
      if (n == poke) begin sprite_code = 2'd0; tile_x = 10'd0; tile_y = 9'd0; opaque = 1'b1; end
      if (done) begin done_cyc = n; break; end
      @(posedge Clk); #1; n++;
    end
    start = 1'b0;
    fb_ready_drv(1'b1);
  endtask

  task automatic fb_ready_drv(input logic v);
    bus.fb_ready = v;
  endtask

  task automatic test_reset;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", done); end
    n_cmp++; if (bus.fb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_fb_valid got %0b want 0", bus.fb_valid); end
    n_cmp++; if (bus.rom_addr !== 7'd0) begin n_bad++; $display("FAIL reset_rom_addr got %0d want 0", bus.rom_addr); end
    n_cmp++; if (bus.fb_addr !== 19'd0) begin n_bad++; $display("FAIL reset_fb_addr got %0d want 0", bus.fb_addr); end
    @(posedge Clk); #1;
    Reset_n = 1'b1;
  endtask

  task automatic test_opaque_wall;
    int dc;
    run_sprite(2'd0, 10'd0, 9'd0, 1'b1, 0, 0, dc);
    n_cmp++; if (wr_cnt != 1024) begin n_bad++; $display("FAIL wall_writes got %0d want 1024", wr_cnt); end
    n_cmp++; if (got(0) != 1) begin n_bad++; $display("FAIL wall_addr0 got %0d want 1", got(0)); end
    n_cmp++; if (got(31) != 1) begin n_bad++; $display("FAIL wall_addr31 got %0d want 1", got(31)); end
    n_cmp++; if (got(640) != 1) begin n_bad++; $display("FAIL wall_addr640 got %0d want 1", got(640)); end
    n_cmp++; if (got(641) != 0) begin n_bad++; $display("FAIL wall_addr641 got %0d want 0", got(641)); end
    n_cmp++; if (dc != 1057) begin n_bad++; $display("FAIL wall_done_cycle got %0d want 1057", dc); end
  endtask

  task automatic check_player(input string tag, input int dc);
    int row0, bad_walk;
    row0 = 0; bad_walk = 0;
    foreach (wr_data[a]) if (a >= 32000 && a < 32640) row0++;
    for (int i = 0; i < rom_q.size(); i++) if (rom_q[i] != 7'(64 + i)) bad_walk++;
    n_cmp++; if (row0 != 4) begin n_bad++; $display("FAIL %s_row0_count got %0d want 4", tag, row0); end
    n_cmp++; if (got(32100) + got(32101) + got(32130) + got(32131) != 4)
      begin n_bad++; $display("FAIL %s_row0_addrs got %0d %0d %0d %0d want 1 1 1 1", tag,
                              got(32100), got(32101), got(32130), got(32131)); end
    n_cmp++; if (wr_cnt != 128) begin n_bad++; $display("FAIL %s_writes got %0d want 128", tag, wr_cnt); end
    n_cmp++; if (wr_zero != 0) begin n_bad++; $display("FAIL %s_zero_writes got %0d want 0", tag, wr_zero); end
    n_cmp++; if (rom_q.size() != 32 || bad_walk != 0)
      begin n_bad++; $display("FAIL %s_rom_walk got size %0d bad %0d want size 32 bad 0", tag, rom_q.size(), bad_walk); end
    n_cmp++; if (dc != 1057) begin n_bad++; $display("FAIL %s_done_cycle got %0d want 1057", tag, dc); end
  endtask

  task automatic test_transparent_player;
    int dc;
    run_sprite(2'd2, 10'd100, 9'd50, 1'b0, 0, 0, dc);
    check_player("player", dc);
  endtask

  task automatic test_backpressure;
    int dc;
    run_sprite(2'd0, 10'd0, 9'd0, 1'b1, 5, 0, dc);
    n_cmp++; if (st_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_held got %0b want 1", st_valid); end
    n_cmp++; if (st_addr !== 19'd0 || st_data !== 1'b1)
      begin n_bad++; $display("FAIL bp_first_write got addr %0d data %0b want addr 0 data 1", st_addr, st_data); end
    n_cmp++; if (st_stable !== 1'b1) begin n_bad++; $display("FAIL bp_stable got %0b want 1", st_stable); end
    n_cmp++; if (wr_cnt != 1024) begin n_bad++; $display("FAIL bp_writes got %0d want 1024", wr_cnt); end
    n_cmp++; if (got(1) != 1) begin n_bad++; $display("FAIL bp_addr1 got %0d want 1", got(1)); end
    n_cmp++; if (dc != 1062) begin n_bad++; $display("FAIL bp_done_cycle got %0d want 1062", dc); end
  endtask

  task automatic test_clipping;
    int dc;
    run_sprite(2'd1, 10'd620, 9'd470, 1'b1, 0, 0, dc);
    n_cmp++; if (wr_cnt != 200) begin n_bad++; $display("FAIL clip_writes got %0d want 200", wr_cnt); end
    n_cmp++; if (got(301420) != 0 || got(301421) != 1)
      begin n_bad++; $display("FAIL clip_origin got %0d %0d want 0 1", got(301420), got(301421)); end
    n_cmp++; if (got(307199) != 1) begin n_bad++; $display("FAIL clip_corner got %0d want 1", got(307199)); end
    n_cmp++; if (got(301440) != -1) begin n_bad++; $display("FAIL clip_x_edge got %0d want -1", got(301440)); end
    n_cmp++; if (dc != 1057) begin n_bad++; $display("FAIL clip_done_cycle got %0d want 1057", dc); end
  endtask

  task automatic test_start_ignored;
    int dc;
    run_sprite(2'd2, 10'd100, 9'd50, 1'b0, 0, 100, dc);
    check_player("busy_start", dc);
  endtask

  task automatic test_reset_restart;
    int dc;
    @(posedge Clk); #1;
    start = 1'b1; sprite_code = 2'd0; tile_x = 10'd0; tile_y = 9'd0; opaque = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (39) @(posedge Clk);
    #1;
    n_cmp++; if (bus.fb_valid !== 1'b1 || busy !== 1'b1)
      begin n_bad++; $display("FAIL mid_sprite_active got valid %0b busy %0b want 1 1", bus.fb_valid, busy); end
    @(negedge Clk); #2;
    Reset_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done, bus.fb_valid} !== 3'b000 || bus.rom_addr !== 7'd0 || bus.fb_addr !== 19'd0)
      begin n_bad++; $display("FAIL async_reset got busy %0b done %0b valid %0b rom %0d fb %0d want all 0",
                              busy, done, bus.fb_valid, bus.rom_addr, bus.fb_addr); end
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    run_sprite(2'd2, 10'd100, 9'd50, 1'b0, 0, 0, dc);
    n_cmp++; if (rom_q.size() == 0 || rom_q[0] != 7'd64)
      begin n_bad++; $display("FAIL restart_first_row got %0d want 64", rom_q.size() ? rom_q[0] : 7'd0); end
    check_player("restart", dc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    Reset_n = 1'b0; start = 1'b0; sprite_code = 2'd0; tile_x = '0; tile_y = '0; opaque = 1'b0;
    bus.fb_ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    test_reset();
    test_opaque_wall();
    test_transparent_player();
    test_backpressure();
    test_clipping();
    test_start_ignored();
    test_reset_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
